// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: rate-controlled two-byte SPI conversion frames for an
// 8-channel 12-bit serial ADC, driven through a byte-level spi_master
// handshake. Each completed frame yields a 12-bit sample tagged with the
// channel it belongs to. The ADC answers for the address sent one frame
// earlier, so the first frame after reset or after an abort is discarded.
// Optional feature: define ADC_AVG_EN to average 2^AVG_LOG2 consecutive
// samples of one channel before presenting a result.
module adc_frame_sequencer #(
  parameter int SAMPLE_DIV   = 5000,
  parameter int CS_SETUP_CYC = 4,
  parameter int TIMEOUT_CYC  = 256,
  parameter int AVG_LOG2     = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        enable,
  input  logic [2:0]  channel,
  output logic [7:0]  spi_tx_byte,
  output logic        spi_tx_dv,
  input  logic        spi_tx_ready,
  input  logic        spi_rx_dv,
  input  logic [7:0]  spi_rx_byte,
  output logic        adc_cs_n,
  output logic [11:0] sample,
  output logic [2:0]  sample_chan,
  output logic        sample_valid,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int RW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(CS_SETUP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CS_LAST   = CW'(CS_SETUP_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, CS_HOLD
  } state_t;

  state_t        state_q;
  logic [RW-1:0] rate_q, rate_d;
  logic [CW-1:0] cs_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [2:0]    cur_ch_q, prev_ch_q;
  logic [3:0]    msb_q;
  logic          prime_q;
  logic          cs_n_q, tx_dv_q, sample_valid_q, timeout_err_q, overrun_q;
  logic [7:0]    tx_byte_q;
  logic [11:0]   sample_q;
  logic [2:0]    sample_chan_q;
  logic          tick, to_expire;
  logic [11:0]   raw_sample_d;

  // Frame-rate tick; the counter is parked at zero while disabled
  always_comb begin
    rate_d = rate_q + RW'(1);
    if (!enable || rate_q == RATE_LAST) rate_d = '0;
  end

  assign tick         = enable && (rate_q == RATE_LAST);
  assign to_expire    = (state_q == WAIT_HI || state_q == WAIT_LO) && !spi_rx_dv &&
                        (to_cnt_q == TO_LAST);
  assign raw_sample_d = {msb_q, spi_rx_byte};

  // Rate counter register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) rate_q <= '0;
    else          rate_q <= rate_d;
  end

`ifdef ADC_AVG_EN
  localparam int AW = 12 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] AVG_N = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

  logic [AW-1:0]     acc_q, acc_sum_d;
  logic [AVG_LOG2:0] acc_cnt_q, acc_cnt_d;
  logic [2:0]        acc_ch_q;
  logic              acc_restart, acc_full;

  // Running sum; restarts when empty or when the sample channel changes
  always_comb begin
    acc_restart = (acc_cnt_q == '0) || (acc_ch_q != prev_ch_q);
    acc_sum_d   = (acc_restart ? '0 : acc_q) + AW'(raw_sample_d);
    acc_cnt_d   = (acc_restart ? '0 : acc_cnt_q) + (AVG_LOG2 + 1)'(1);
    acc_full    = (acc_cnt_d == AVG_N);
  end

  // Accumulator data path; validity is tracked by acc_cnt_q in the FSM
  always_ff @(posedge clk) begin
    if (state_q == WAIT_LO && spi_rx_dv && !prime_q) begin
      acc_q    <= acc_sum_d;
      acc_ch_q <= prev_ch_q;
    end
  end
`endif

  // Frame sequencer with registered SPI, chip-select and sample outputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q        <= IDLE;
      cs_cnt_q       <= '0;
      to_cnt_q       <= '0;
      cur_ch_q       <= '0;
      prev_ch_q      <= '0;
      msb_q          <= '0;
      prime_q        <= 1'b1;
      cs_n_q         <= 1'b1;
      tx_dv_q        <= 1'b0;
      tx_byte_q      <= 8'h00;
      sample_q       <= '0;
      sample_chan_q  <= '0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef ADC_AVG_EN
      acc_cnt_q      <= '0;
`endif
    end else begin
      tx_dv_q        <= 1'b0;
      sample_valid_q <= 1'b0;
      if (!enable)                        begin timeout_err_q <= 1'b0; overrun_q <= 1'b0; end
      else if (tick && state_q != IDLE)   overrun_q <= 1'b1;

      if (to_expire) begin
        // ADC stopped answering: release it and re-prime the pipeline
        cs_n_q        <= 1'b1;
        timeout_err_q <= 1'b1;
        prime_q       <= 1'b1;
        cs_cnt_q      <= '0;
        state_q       <= CS_HOLD;
`ifdef ADC_AVG_EN
        acc_cnt_q     <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: if (tick) begin
            cur_ch_q <= channel;
            cs_n_q   <= 1'b0;
            cs_cnt_q <= '0;
            state_q  <= CS_SETUP;
          end
          CS_SETUP: begin
            if (cs_cnt_q == CS_LAST) state_q  <= SEND_HI;
            else                     cs_cnt_q <= cs_cnt_q + CW'(1);
          end
          SEND_HI: if (spi_tx_ready) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= {2'b00, cur_ch_q, 3'b000};
            to_cnt_q  <= '0;
            state_q   <= WAIT_HI;
          end
          WAIT_HI: begin
            if (spi_rx_dv) begin
              msb_q   <= spi_rx_byte[3:0];
              state_q <= SEND_LO;
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end
          SEND_LO: if (spi_tx_ready) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= 8'h00;
            to_cnt_q  <= '0;
            state_q   <= WAIT_LO;
          end
          WAIT_LO: begin
            if (spi_rx_dv) begin
              cs_n_q    <= 1'b1;
              cs_cnt_q  <= '0;
              state_q   <= CS_HOLD;
              prev_ch_q <= cur_ch_q;
              prime_q   <= 1'b0;
`ifdef ADC_AVG_EN
              if (!prime_q) begin
                if (acc_full) begin
                  sample_q       <= acc_sum_d[AVG_LOG2 +: 12];
                  sample_chan_q  <= prev_ch_q;
                  sample_valid_q <= 1'b1;
                  acc_cnt_q      <= '0;
                end else begin
                  acc_cnt_q      <= acc_cnt_d;
                end
              end
`else
              if (!prime_q) begin
                sample_q       <= raw_sample_d;
                sample_chan_q  <= prev_ch_q;
                sample_valid_q <= 1'b1;
              end
`endif
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end
          CS_HOLD: begin
            if (cs_cnt_q == CS_LAST) state_q  <= IDLE;
            else                     cs_cnt_q <= cs_cnt_q + CW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign spi_tx_dv    = tx_dv_q;
  assign spi_tx_byte  = tx_byte_q;
  assign sample       = sample_q;
  assign sample_chan  = sample_chan_q;
  assign sample_valid = sample_valid_q;
  assign timeout_err  = timeout_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed bench for adc_frame_sequencer with a behavioural spi_master/ADC
// model answering each transmitted byte after a programmable latency.
module tb_adc_frame_sequencer;
  localparam int SAMPLE_DIV   = 20;
  localparam int CS_SETUP_CYC = 2;
  localparam int TIMEOUT_CYC  = 16;
  localparam int AVG_LOG2     = 2;

  logic        clk = 1'b0;
  logic        reset_b, enable;
  logic [2:0]  channel;
  logic [7:0]  spi_tx_byte;
  logic        spi_tx_dv;
  logic        spi_tx_ready;
  logic        spi_rx_dv;
  logic [7:0]  spi_rx_byte;
  logic        adc_cs_n;
  logic [11:0] sample;
  logic [2:0]  sample_chan;
  logic        sample_valid, timeout_err, overrun;

  adc_frame_sequencer #(
    .SAMPLE_DIV(SAMPLE_DIV), .CS_SETUP_CYC(CS_SETUP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .channel(channel),
    .spi_tx_byte(spi_tx_byte), .spi_tx_dv(spi_tx_dv), .spi_tx_ready(spi_tx_ready),
    .spi_rx_dv(spi_rx_dv), .spi_rx_byte(spi_rx_byte), .adc_cs_n(adc_cs_n),
    .sample(sample), .sample_chan(sample_chan), .sample_valid(sample_valid),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, valid_cnt = 0, frame_cnt = 0, start_cnt = 0;
  int frame_bytes = 0, last_frame_bytes = 0, proto_viol = 0, width_viol = 0;
  int last_rx_cyc = 0, last_dv_cyc = 0, cs_rise_cyc = 0, last_lat = 0;
  int wait_cnt = 0, lat = 1, idx = 0;
  bit busy = 0, mute = 0, prev_valid = 0, prev_cs = 1;
  logic [7:0]  resp_hi = 8'h07, resp_lo = 8'h08, first_byte = 8'h00, second_byte = 8'h00;
  logic [11:0] last_sample = '0;
  logic [2:0]  last_chan = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    int target = frame_cnt + n;
    int k = 0;
    while (frame_cnt < target && k < 400) begin @(posedge clk); #2; k++; end
    check("frame_end_wait", 32'(frame_cnt >= target), 1);
  endtask

  task automatic wait_cs_fall();
    int target = start_cnt + 1;
    int k = 0;
    while (start_cnt < target && k < 400) begin @(posedge clk); #2; k++; end
    check("frame_start_wait", 32'(start_cnt >= target), 1);
  endtask

  // SPI master + ADC model and output monitor, sampled 1ns after each edge
  initial begin
    spi_tx_ready = 1'b1; spi_rx_dv = 1'b0; spi_rx_byte = 8'h00;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (sample_valid) begin
        valid_cnt++; last_sample = sample; last_chan = sample_chan;
        last_lat = cyc - last_rx_cyc;
        if (prev_valid) width_viol++;
      end
      prev_valid = sample_valid;
      if (!prev_cs && adc_cs_n) begin frame_cnt++; last_frame_bytes = frame_bytes; cs_rise_cyc = cyc; end
      if (prev_cs && !adc_cs_n) begin start_cnt++; frame_bytes = 0; end
      prev_cs = adc_cs_n;
      spi_rx_dv = 1'b0;
      if (spi_tx_dv) begin
        if (!spi_tx_ready || adc_cs_n) proto_viol++;
        if (frame_bytes == 0) first_byte = spi_tx_byte; else second_byte = spi_tx_byte;
        frame_bytes++; last_dv_cyc = cyc;
        spi_tx_ready = 1'b0; busy = 1; wait_cnt = lat;
      end else if (busy) begin
        if (wait_cnt == 0) begin
          busy = 0; spi_tx_ready = 1'b1;
          if (!mute) begin
            spi_rx_dv = 1'b1; spi_rx_byte = (idx == 0) ? resp_hi : resp_lo;
            idx++; last_rx_cyc = cyc;
          end
        end else wait_cnt--;
      end
      if (adc_cs_n) begin idx = 0; busy = 0; spi_tx_ready = 1'b1; spi_rx_dv = 1'b0; end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int vc, s;
    reset_b = 1'b0; enable = 1'b0; channel = 3'd0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_tx_dv", spi_tx_dv, 0);
    check("rst_tx_byte", spi_tx_byte, 8'h00);
    check("rst_sample", sample, 0);
    check("rst_sample_chan", sample_chan, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk); reset_b = 1'b1; enable = 1'b1;

`ifdef ADC_AVG_EN
    resp_hi = 8'h00; resp_lo = 8'd100;
    wait_frames(1);
    check("avg_prime_no_valid", valid_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      resp_lo = 8'(100 + i);
      wait_frames(1);
      if (i < 3) check("avg_partial_no_valid", valid_cnt, 0);
      else begin
        check("avg_one_valid", valid_cnt, 1);
        check("avg_sample", last_sample, 12'd101);
        check("avg_chan", last_chan, 0);
      end
    end
`else
    // Frame 1 primes the ADC; frame 2 returns 0x708 for channel 0
    wait_frames(1);
    check("f1_first_byte", first_byte, 8'h00);
    check("f1_second_byte", second_byte, 8'h00);
    check("f1_no_valid", valid_cnt, 0);
    wait_frames(1);
    check("f2_valid_cnt", valid_cnt, 1);
    check("f2_sample", last_sample, 12'h708);
    check("f2_chan", last_chan, 0);
    check("f2_latency", last_lat, 1);
    check("f2_bytes", last_frame_bytes, 2);

    // Channel switch between frames, then a change while a frame is active
    channel = 3'd5;
    wait_frames(1);
    check("f3_first_byte", first_byte, 8'h28);
    check("f3_chan", last_chan, 0);
    wait_frames(1);
    check("f4_chan", last_chan, 5);
    wait_cs_fall();
    channel = 3'd1;
    wait_frames(1);
    check("f5_latched_byte", first_byte, 8'h28);
    check("f5_chan", last_chan, 5);
    check("f5_valid_cnt", valid_cnt, 4);

    // Upper nibble of the first response is masked
    resp_hi = 8'hF7; resp_lo = 8'hFF;
    wait_frames(1);
    check("f6_first_byte", first_byte, 8'h08);
    check("f6_sample", last_sample, 12'h7FF);
    check("f6_chan", last_chan, 5);

    // ADC never answers: abort after TIMEOUT_CYC, then one primed frame
    mute = 1;
    wait_frames(1);
    check("to_delay", cs_rise_cyc - last_dv_cyc, TIMEOUT_CYC);
    check("to_err", timeout_err, 1);
    check("to_no_valid", valid_cnt, 5);
    check("to_bytes", last_frame_bytes, 1);
    mute = 0;
    wait_frames(1);
    check("to_reprime_no_valid", valid_cnt, 5);
    check("to_err_sticky", timeout_err, 1);
    wait_frames(1);
    check("to_recover_valid", valid_cnt, 6);
    check("to_recover_sample", last_sample, 12'h7FF);
    check("to_recover_chan", last_chan, 1);

    // Disabling clears the sticky flags
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("dis_timeout_clr", timeout_err, 0);
    check("dis_overrun_clr", overrun, 0);
    enable = 1'b1;

    // Enable dropped mid-frame: frame still completes with a valid
    wait_cs_fall();
    enable = 1'b0;
    wait_frames(1);
    check("en_drop_valid", valid_cnt, 7);
    s = start_cnt;
    repeat (60) @(posedge clk);
    #2;
    check("en_drop_no_start", start_cnt, s);
    check("en_drop_cs_high", adc_cs_n, 1);
    enable = 1'b1;

    // Frames longer than the rate period raise overrun but stay well-formed
    check("ovr_clear_before", overrun, 0);
    lat = 6;
    wait_frames(3);
    check("ovr_set", overrun, 1);
    check("ovr_valid_cnt", valid_cnt, 10);
    check("ovr_bytes", last_frame_bytes, 2);
    check("ovr_sample", last_sample, 12'h7FF);

    // Reset during WAIT_LO acts immediately
    begin
      int k = 0;
      while (!(adc_cs_n == 1'b0 && frame_bytes == 2) && k < 200) begin @(posedge clk); #2; k++; end
      check("wait_lo_reached", 32'(k < 200), 1);
    end
    @(posedge clk); #2;
    reset_b = 1'b0;
    #1;
    check("midrst_cs_n", adc_cs_n, 1);
    check("midrst_tx_dv", spi_tx_dv, 0);
    check("midrst_sample", sample, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset_b = 1'b1; lat = 1;
    vc = valid_cnt;
    wait_frames(1);
    check("postrst_prime_no_valid", valid_cnt, vc);
    wait_frames(1);
    check("postrst_valid", valid_cnt, vc + 1);
    check("postrst_sample", last_sample, 12'h7FF);
    check("postrst_chan", last_chan, 1);
`endif

    check("protocol_violations", proto_viol, 0);
    check("valid_width_violations", width_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
Upstream stage of the PI control loop. It sequences two-byte SPI conversion frames for the 8-channel 12-bit serial ADC through the existing byte-level spi_master handshake, and drives ADC chip select per frame. It assembles each 12-bit result and presents it to the PI_Controller as a single-cycle-valid sample with its channel tag. It replaces free-running byte capture with a deterministic, rate-controlled, timeout-protected frame.

Parameters:
SAMPLE_DIV, 5000, clk cycles between frame starts (10 kHz at 50 MHz); minimum 2
CS_SETUP_CYC, 4, cycles between CS_N fall and first byte, and minimum CS_N high time between frames; minimum 1
TIMEOUT_CYC, 256, maximum cycles allowed in a WAIT state before the frame is aborted
AVG_LOG2, 2, log2 of the averaging depth; used only with ADC_AVG_EN

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset_b  in  1  asynchronous active-low reset
enable  in  1  1 = run frames; 0 = stop after the current frame completes
channel  in  3  ADC address to request; latched at frame start
spi_tx_byte  out  8  byte to spi_master i_TX_Byte
spi_tx_dv  out  1  1-cycle pulse to spi_master i_TX_DV
spi_tx_ready  in  1  from spi_master o_TX_Ready
spi_rx_dv  in  1  from spi_master o_RX_DV (1-cycle pulse)
spi_rx_byte  in  8  from spi_master o_RX_Byte
adc_cs_n  out  1  ADC chip select, active low
sample  out  12  conversion result, held between valids
sample_chan  out  3  channel that sample belongs to
sample_valid  out  1  1-cycle strobe, new sample
timeout_err  out  1  sticky; a frame was aborted
overrun  out  1  sticky; a rate tick arrived while a frame was busy

Behaviour:
- Reset values: adc_cs_n=1, spi_tx_dv=0, spi_tx_byte=0x00, sample=0, sample_chan=0, sample_valid=0, timeout_err=0, overrun=0, state=IDLE, prime=1.
- Rate counter: counts 0..SAMPLE_DIV-1 and ticks at SAMPLE_DIV-1. It is held at 0 while enable=0. timeout_err and overrun clear when enable=0.
- States: IDLE -> CS_SETUP -> SEND_HI -> WAIT_HI -> SEND_LO -> WAIT_LO -> CS_HOLD -> IDLE.
- IDLE: on tick with enable=1, latch channel into cur_ch, drive adc_cs_n=0, go to CS_SETUP.
- CS_SETUP: wait CS_SETUP_CYC cycles.
- SEND_HI: wait for spi_tx_ready=1. Then pulse spi_tx_dv for exactly 1 cycle with spi_tx_byte={2'b00,cur_ch,3'b000}. Never assert spi_tx_dv while spi_tx_ready=0.
- WAIT_HI: on spi_rx_dv, capture msb=spi_rx_byte.
- SEND_LO: same handshake as SEND_HI, with spi_tx_byte=0x00.
- WAIT_LO: on spi_rx_dv, capture lsb. On the next cycle: adc_cs_n=1, sample={msb[3:0],lsb}, sample_chan=prev_ch, and sample_valid=1 unless prime=1. Then prev_ch<=cur_ch, prime<=0.
- The ADC returns the result for the address sent in the previous frame. The first frame after reset, and after any abort, is therefore discarded (prime=1, no valid).
- CS_HOLD: keep adc_cs_n=1 for CS_SETUP_CYC cycles, then go to IDLE.
- Latency: sample_valid is asserted 1 cycle after the second spi_rx_dv.
- msb[7:4] is ignored (masked).
- Timeout: the counter starts on spi_tx_dv and counts while in WAIT_HI or WAIT_LO. When it reaches TIMEOUT_CYC: adc_cs_n=1, timeout_err=1, prime=1, go to CS_HOLD, no valid.
- Tick while not in IDLE: tick dropped, overrun=1, current frame unaffected.
- enable falling mid-frame: the current frame completes normally, including valid; no new frame starts.
- channel changing mid-frame: ignored until the next frame start.
- spi_rx_dv outside a WAIT state: ignored.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously).

Optional Feature:
ADC_AVG_EN defined:
- Accumulate 2^AVG_LOG2 consecutive valid samples of the same sample_chan in a (12+AVG_LOG2)-bit accumulator.
- Output the accumulator >> AVG_LOG2 (truncated), with one sample_valid per 2^AVG_LOG2 frames.
- A change of sample_chan, or an abort, clears the accumulator and its count.

ADC_AVG_EN undefined:
- No accumulator logic; every non-primed frame produces sample_valid.

Test Plan:
1. Reset, enable=1, channel=0, SPI model returns 0x07,0x08 per frame -> frame 1: tx bytes 0x00,0x00 and no valid; frame 2: sample=0x708, sample_chan=0, one valid pulse; adc_cs_n low for the whole frame.
2. channel switched 0->5 between frames -> next frame sends 0x28; the following valid has sample_chan=0, and the one after has sample_chan=5.
3. SPI model returns 0xF7,0xFF -> sample=0x7FF.
4. SPI model never pulses spi_rx_dv -> TIMEOUT_CYC cycles after spi_tx_dv: adc_cs_n=1, timeout_err=1; next completed frame gives no valid; the frame after that gives a valid.
5. SAMPLE_DIV=20 with a frame longer than 20 cycles -> overrun=1, every frame still well-formed, spi_tx_dv never asserted while spi_tx_ready=0.
6. reset_b asserted during WAIT_LO -> adc_cs_n=1 and spi_tx_dv=0 in the same cycle; first frame after release gives no valid. With ADC_AVG_EN and AVG_LOG2=2, samples 100,101,102,103 on one channel -> a single valid with sample=101.
